// File: rtl/carbon_arb_pkg.sv
// Shared types and default constants for the carbon fabric master scheduler.
package carbon_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_e;

  localparam int unsigned MAX_HOLD_DEF     = 4;
  localparam int unsigned TIMEOUT_CYC_DEF  = 64;
  localparam logic [7:0]  HI_PRIO_MASK_DEF = 8'h01;

endpackage

// File: rtl/carbon_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo M.
module carbon_rr_pick #(
  parameter int unsigned M = 4
) (
  input  logic [M-1:0]         req_i,
  input  logic [$clog2(M)-1:0] ptr_i,
  output logic [M-1:0]         gnt_o,
  output logic                 valid_o
);

  localparam int unsigned IW = $clog2(M);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < M; i++) begin
      idx = (32'(ptr_i) + i) % M;
      if (!found && req_i[IW'(idx)]) begin
        gnt_o[IW'(idx)] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/carbon_master_sched.sv
// Two-class round-robin scheduler for fabric masters sharing one port,
// with locked transaction hold, abort handling and a BUSY watchdog.
module carbon_master_sched
  import carbon_arb_pkg::*;
#(
  parameter int unsigned M            = 4,
  parameter logic [M-1:0] HI_PRIO_MASK = HI_PRIO_MASK_DEF[M-1:0],
  parameter int unsigned MAX_HOLD     = MAX_HOLD_DEF,
  parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [M-1:0]         req,
  input  logic [M-1:0]         lock,
  input  logic                 xfer_done,
  output logic [M-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(M)-1:0] gnt_id,
  output logic                 timeout_pulse,
  output logic [$clog2(M)-1:0] err_owner
);

  localparam int unsigned IW = $clog2(M);
  localparam int unsigned HW = $clog2(MAX_HOLD) + 1;
  localparam int unsigned WW = 16;

  sched_state_e   state_q, state_d;
  logic [M-1:0]   gnt_q, gnt_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IW-1:0]  gnt_id_q, gnt_id_d;
  logic           tmo_q, tmo_d;
  logic [IW-1:0]  err_q, err_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [WW-1:0]  wdog_q, wdog_d;

  logic          busy, keep, abort, tmo, rel;
  logic [IW-1:0] next_ptr, pick_ptr, win_id;
  logic [M-1:0]  hi_gnt, lo_gnt, win;
  logic          hi_valid, lo_valid, any_req;

  assign busy     = (state_q == BUSY);
  assign keep     = busy && xfer_done && lock[gnt_id_q] && (hold_q < HW'(MAX_HOLD - 1));
  assign abort    = busy && !xfer_done && !req[gnt_id_q];
  assign tmo      = busy && !xfer_done && req[gnt_id_q] && (wdog_q == WW'(TIMEOUT_CYC - 1));
  assign rel      = (busy && xfer_done && !keep) || abort || tmo;
  assign next_ptr = IW'((32'(gnt_id_q) + 1) % M);

  // Owner stays in the pick set: starting at owner+1 makes it last in its
  // class, so it only wins when nobody else of that class is requesting.
  assign pick_ptr = rel ? next_ptr : rr_q;

  carbon_rr_pick #(.M(M)) u_pick_hi (
    .req_i   (req & HI_PRIO_MASK),
    .ptr_i   (pick_ptr),
    .gnt_o   (hi_gnt),
    .valid_o (hi_valid)
  );

  carbon_rr_pick #(.M(M)) u_pick_lo (
    .req_i   (req & ~HI_PRIO_MASK),
    .ptr_i   (pick_ptr),
    .gnt_o   (lo_gnt),
    .valid_o (lo_valid)
  );

  assign win     = hi_valid ? hi_gnt : lo_gnt;
  assign any_req = hi_valid || lo_valid;

  always_comb begin
    win_id = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (win[i]) win_id = IW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    tmo_d       = 1'b0;
    err_d       = err_q;
    rr_d        = rr_q;
    hold_d      = hold_q;
    wdog_d      = wdog_q;

    if (!busy) begin
      if (any_req) begin
        state_d     = BUSY;
        gnt_d       = win;
        gnt_valid_d = 1'b1;
        gnt_id_d    = win_id;
        hold_d      = '0;
        wdog_d      = '0;
      end
    end else if (keep) begin
      hold_d = hold_q + 1'b1;
      wdog_d = '0;
    end else if (rel) begin
      rr_d = next_ptr;
      if (tmo) begin
        tmo_d = 1'b1;
        err_d = gnt_id_q;
      end
      hold_d = '0;
      wdog_d = '0;
      if (any_req) begin
        gnt_d    = win;
        gnt_id_d = win_id;
      end else begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
      end
    end else begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      tmo_q       <= 1'b0;
      err_q       <= '0;
      rr_q        <= '0;
      hold_q      <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      rr_q        <= rr_d;
      hold_q      <= hold_d;
      wdog_q      <= wdog_d;
    end
  end

  assign gnt           = gnt_q;
  assign gnt_valid     = gnt_valid_q;
  assign gnt_id        = gnt_id_q;
  assign timeout_pulse = tmo_q;
  assign err_owner     = err_q;

endmodule

// File: doc/carbon_master_sched.md
CARBON_MASTER_SCHED -- requirements
Module: carbon_master_sched

Interface
REQ-001 SHALL have parameter M, default 4: number of requesters (fabric masters sharing one port); legal range 2..8.
REQ-002 SHALL have parameter HI_PRIO_MASK [M-1:0], default 4'b0001: requesters in the high class; CPU memory master is bit 0.
REQ-003 SHALL have parameter MAX_HOLD, default 4: maximum consecutive locked transactions per grant.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 64: BUSY cycles without xfer_done before forced release; legal range 2..65535.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port req, input, M: per-requester request level.
REQ-008 SHALL have port lock, input, M: requester wants grant retained across transactions.
REQ-009 SHALL have port xfer_done, input, 1: one-cycle pulse, the granted requester's transaction completed.
REQ-010 SHALL have port gnt, output, M: one-hot grant, registered.
REQ-011 SHALL have port gnt_valid, output, 1: OR of gnt, registered.
REQ-012 SHALL have port gnt_id, output, $clog2(M): index of owner; 0 when idle.
REQ-013 SHALL have port timeout_pulse, output, 1: one-cycle pulse on forced release.
REQ-014 SHALL have port err_owner, output, $clog2(M): sticky index of the last timed-out owner.

Function
REQ-015 SHALL implement states IDLE and BUSY; gnt_valid=1 exactly in BUSY.
REQ-016 IDLE with any req high SHALL enter BUSY next cycle with gnt set to the winner (1-cycle request-to-grant latency).
REQ-017 Winner SHALL be chosen from the high class if any high-class req is set, else from the low class; within a class, round-robin starting at rr_ptr.
REQ-018 rr_ptr SHALL advance to (owner+1) mod M on every release, including forced release; it is shared by both classes.
REQ-019 BUSY with xfer_done=1: if lock[owner]=1 and hold_cnt<MAX_HOLD-1, SHALL keep grant and increment hold_cnt; otherwise SHALL release.
REQ-020 On release, if any req (evaluated with updated rr_ptr, owner excluded) is high, SHALL grant the new winner next cycle with no idle bubble; else SHALL go IDLE.
REQ-021 On release, if only the releasing owner is requesting, SHALL re-grant it next cycle (no starvation of a sole requester).
REQ-022 BUSY with req[owner]=0 and xfer_done=0 SHALL be treated as abort: release as in REQ-020, no timeout_pulse.
REQ-023 wdog_cnt SHALL clear on grant and on xfer_done, otherwise increment in BUSY; on reaching TIMEOUT_CYC-1 SHALL force release, pulse timeout_pulse, load err_owner.
REQ-024 xfer_done during IDLE SHALL be ignored.
REQ-025 Simultaneous xfer_done and timeout SHALL count as xfer_done; no timeout_pulse.
REQ-026 hold_cnt SHALL clear on every new grant; it SHALL NOT wrap.
REQ-027 gnt SHALL never have more than one bit set; changes to req/lock SHALL affect gnt only at the next clock edge.

Reset
REQ-028 Asserting rst_n low SHALL immediately force IDLE, gnt=0, gnt_valid=0, gnt_id=0, timeout_pulse=0, err_owner=0, rr_ptr=0, hold_cnt=0, wdog_cnt=0, including mid-transaction.
REQ-029 After rst_n deasserts, the first grant SHALL follow REQ-016 with rr_ptr=0.

Structure
REQ-030 State enum, default MAX_HOLD/TIMEOUT_CYC constants, and HI_PRIO_MASK default SHALL live in shared package carbon_arb_pkg.
REQ-031 Round-robin pick (request vector, pointer -> one-hot, valid) SHALL be sub-module carbon_rr_pick, instantiated once per class.
REQ-032 All outputs SHALL be driven directly from flops.

Verification (M=4, HI_PRIO_MASK=0001, MAX_HOLD=4, TIMEOUT_CYC=64)
REQ-033 req=1110 from reset, xfer_done every 3rd cycle, lock=0 -> gnt sequence 0010,0100,1000,0010; gnt_id 1,2,3,1.
REQ-034 req=0011, both requesting -> requester 0 granted first and again after each release while req[0]=1; requester 1 waits.
REQ-035 req=0100, lock=0100, 6 xfer_done pulses -> grant held for 4 transactions, released, re-granted to 2 next cycle, gnt_valid continuous.
REQ-036 Grant to 3 with no xfer_done for 64 cycles -> timeout_pulse at cycle 64 after grant, err_owner=3, gnt=0 or next winner the following cycle.
REQ-037 rst_n low while BUSY with gnt=0100 -> gnt=0, gnt_valid=0 same cycle, without a clock edge; first grant after release goes to lowest requesting index.
REQ-038 xfer_done on the same cycle wdog_cnt hits 63 -> normal release, timeout_pulse=0, err_owner unchanged.
